// File: rtl/modbus_tx_frame_sched.sv
// Modbus RTU response frame scheduler.
// Buffers the payload, waits out the t3.5 line silence, feeds uart_byte_tx one
// byte per tx_start/tx_done handshake and appends CRC-16/Modbus (low byte first).
module modbus_tx_frame_sched #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int DEPTH     = 256,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          buf_wr_en,
    input  logic [AW-1:0] buf_wr_addr,
    input  logic [7:0]    buf_wr_data,
    input  logic          send_req,
    input  logic [AW:0]   send_len,
    output logic          busy,
    output logic          send_done,
    output logic          send_err,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    input  logic          tx_state,
    input  logic          rx_state
);

    // Above 19200 baud the silence is a fixed 1.75 ms, otherwise 3.5 characters of 11 bits.
    localparam longint T35_L = (BAUD_RATE > 19200)
        ? (longint'(CLK_FREQ) * 64'sd7) / 64'sd4000
        : (longint'(CLK_FREQ) * 64'sd385) / (64'sd10 * longint'(BAUD_RATE));
    localparam int            T35_CYC = int'(T35_L);
    localparam int            CW      = $clog2(T35_CYC + 1);
    localparam logic [CW-1:0] T35_MAX = CW'(T35_CYC);
    localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_WAIT   = 3'd4,
        S_CRC_LO = 3'd5,
        S_CRC_HI = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Which byte WAIT is waiting on, so one WAIT state serves payload and CRC bytes.
    typedef enum logic [1:0] {
        PH_DATA   = 2'd0,
        PH_CRC_LO = 2'd1,
        PH_CRC_HI = 2'd2
    } phase_t;

    // One byte of CRC-16/Modbus (reflected poly 0xA001), fully unrolled.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc_in, input logic [7:0] data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    logic [7:0]    mem_q [DEPTH];
    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          busy_q, busy_d;
    logic          send_done_q, send_done_d;
    logic          send_err_q, send_err_d;
    logic          cnt_sat_s;
    logic          len_bad_s;

    assign cnt_sat_s = (cnt_q == T35_MAX);
    assign len_bad_s = (send_len == {(AW + 1){1'b0}}) || (send_len > LEN_MAX);

    // Line-silence counter: any rx/tx activity restarts it, otherwise count up to t3.5.
    always_comb begin
        cnt_d = cnt_q;
        if (rx_state || tx_state) begin
            cnt_d = {CW{1'b0}};
        end else if (!cnt_sat_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frame sequencer: next state, datapath updates and registered output strobes.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        len_d      = len_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        send_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send_req) begin
                    if (len_bad_s) begin
                        send_err_d = 1'b1;
                    end else begin
                        len_d   = send_len;
                        idx_d   = {(AW + 1){1'b0}};
                        crc_d   = 16'hFFFF;
                        phase_d = PH_DATA;
                        state_d = cnt_sat_s ? S_LOAD : S_GAP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_sat_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_LOAD: begin
                // Registered read: the byte lands in tx_data_q for the SEND cycle.
                tx_data_d = mem_q[idx_q[AW-1:0]];
                state_d   = S_SEND;
            end
            S_SEND: begin
                crc_d   = crc16_update(crc_q, tx_data_q);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    case (phase_q)
                        PH_DATA: begin
                            if ((idx_q + (AW + 1)'(1)) < len_q) begin
                                idx_d   = idx_q + (AW + 1)'(1);
                                state_d = S_LOAD;
                            end else begin
                                phase_d   = PH_CRC_LO;
                                tx_data_d = crc_q[7:0];
                                state_d   = S_CRC_LO;
                            end
                        end
                        PH_CRC_LO: begin
                            phase_d   = PH_CRC_HI;
                            tx_data_d = crc_q[15:8];
                            state_d   = S_CRC_HI;
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CRC_LO: state_d = S_WAIT;
            S_CRC_HI: state_d = S_WAIT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        tx_start_d  = (state_d == S_SEND) || (state_d == S_CRC_LO) || (state_d == S_CRC_HI);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        send_done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_DATA;
            cnt_q       <= {CW{1'b0}};
            len_q       <= {(AW + 1){1'b0}};
            idx_q       <= {(AW + 1){1'b0}};
            crc_q       <= 16'hFFFF;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
            send_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            send_done_q <= send_done_d;
            send_err_q  <= send_err_d;
        end
    end

    // Payload buffer write port; locked while a frame is being sent.
    always_ff @(posedge clk) begin
        if (buf_wr_en && !busy_q) begin
            mem_q[buf_wr_addr] <= buf_wr_data;
        end
    end

    assign busy      = busy_q;
    assign send_done = send_done_q;
    assign send_err  = send_err_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_modbus_tx_frame_sched.sv
// Directed bench for modbus_tx_frame_sched with a small uart_byte_tx model.
module tb_modbus_tx_frame_sched;

    // 200 kHz clock above 19200 baud: 200000*7/4000 = 350 cycles of silence.
    localparam int T35      = 350;
    localparam int BYTE_CYC = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       buf_wr_en = 1'b0;
    logic [7:0] buf_wr_addr = 8'h00;
    logic [7:0] buf_wr_data = 8'h00;
    logic       send_req = 1'b0;
    logic [8:0] send_len = 9'd0;
    logic       busy, send_done, send_err, tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       tx_state = 1'b0;
    logic       rx_state = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    int done_cyc = 0;
    bit pending = 1'b0;
    logic [7:0] txq [$];
    int gaps [$];

    logic [7:0] frame1 [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    logic [7:0] frame2 [8] = '{8'h01, 8'h7E, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int         gaps1  [7] = '{2, 2, 2, 2, 2, 1, 1};

    modbus_tx_frame_sched #(
        .CLK_FREQ (200000),
        .BAUD_RATE(115200),
        .DEPTH    (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_wr_en  (buf_wr_en),
        .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data),
        .send_req   (send_req),
        .send_len   (send_len),
        .busy       (busy),
        .send_done  (send_done),
        .send_err   (send_err),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .tx_state   (tx_state),
        .rx_state   (rx_state)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure handshake latencies.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Pulse counters, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (send_done) done_cnt = done_cnt + 1;
        if (send_err)  err_cnt  = err_cnt + 1;
        if (tx_start)  start_cnt = start_cnt + 1;
    end

    // uart_byte_tx model: capture byte on tx_start, stay busy, then pulse tx_done.
    initial begin
        @(posedge clk); #1;
        forever begin
            if (tx_start) begin
                txq.push_back(tx_data);
                if (pending) gaps.push_back(cyc - done_cyc);
                pending  = 1'b0;
                tx_state = 1'b1;
                for (int k = 0; k < BYTE_CYC; k++) begin
                    @(posedge clk); #1;
                end
                tx_done  = 1'b1;
                done_cyc = cyc;
                pending  = 1'b1;
                @(posedge clk); #1;
                tx_done  = 1'b0;
                tx_state = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        buf_wr_en = 1'b1; buf_wr_addr = a; buf_wr_data = d;
        tick();
        buf_wr_en = 1'b0;
    endtask

    task automatic write_frame1();
        for (int i = 0; i < 6; i++) wr(8'(i), frame1[i]);
    endtask

    task automatic clear_obs();
        txq.delete(); gaps.delete(); pending = 1'b0;
        done_cnt = 0; err_cnt = 0; start_cnt = 0;
    endtask

    task automatic request(input logic [8:0] len);
        send_len = len; send_req = 1'b1;
        tick();
        send_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin tick(); n++; end
        check(tag, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [7:0] exp [8]);
        check($sformatf("%s_len", tag), 32'(txq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < txq.size()) check($sformatf("%s_b%0d", tag, i), 32'(txq[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int n;
        // Reset values.
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_send_done", 32'(send_done), 32'd0);
        check("rst_send_err", 32'(send_err), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);

        // Request one cycle after reset, with a same-cycle write of byte 01.
        rst = 1'b0;
        tick();
        buf_wr_en = 1'b1; buf_wr_addr = 8'h00; buf_wr_data = 8'h01;
        request(9'd1);
        buf_wr_en = 1'b0;
        n = 2;
        check("t2_busy", 32'(busy), 32'd1);
        while (!tx_start && n < 2000) begin tick(); n++; end
        // Counter saturates T35 edges after reset release, then GAP->LOAD->SEND.
        check("t2_first_start", 32'(n), 32'(T35 + 2));
        wait_done("t2_done");
        check_frame("t2", 3, frame2);

        // Reference frame on an idle line, with latency and handshake spacing checks.
        write_frame1();
        repeat (T35 + 5) tick();
        clear_obs();
        request(9'd6);
        check("t1_load_no_start", 32'(tx_start), 32'd0);
        tick();
        check("t1_start_n2", 32'(tx_start), 32'd1);
        check("t1_data0", 32'(tx_data), 32'h01);
        wait_done("t1_done");
        check_frame("t1", 8, frame1);
        check("t1_gap_cnt", 32'(gaps.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < gaps.size()) check($sformatf("t1_gap%0d", i), 32'(gaps[i]), 32'(gaps1[i]));
        end
        tick();
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_one_done", 32'(done_cnt), 32'd1);

        // Line activity during GAP restarts the full silence wait.
        clear_obs();
        request(9'd6);
        rx_state = 1'b1;
        repeat (2000) tick();
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_no_start", 32'(start_cnt), 32'd0);
        rx_state = 1'b0;
        tick();
        n = 0;
        while (!tx_start && n < 2000) begin tick(); n++; end
        check("t3_start_after_rx", 32'(n), 32'(T35 + 1));
        wait_done("t3_done");
        check_frame("t3", 8, frame1);

        // Illegal lengths.
        repeat (T35 + 5) tick();
        clear_obs();
        request(9'd0);
        check("t4_err0", 32'(send_err), 32'd1);
        check("t4_busy0", 32'(busy), 32'd0);
        tick();
        check("t4_err_pulse", 32'(send_err), 32'd0);
        request(9'd257);
        check("t4_err257", 32'(send_err), 32'd1);
        check("t4_busy257", 32'(busy), 32'd0);
        repeat (20) tick();
        check("t4_err_cnt", 32'(err_cnt), 32'd2);
        check("t4_no_start", 32'(start_cnt), 32'd0);

        // Reset while waiting on the third byte, then a clean resend.
        write_frame1();
        clear_obs();
        request(9'd6);
        n = 0;
        while (txq.size() < 3 && n < 2000) begin tick(); n++; end
        check("t5_reach_b3", 32'(txq.size()), 32'd3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_tx_start", 32'(tx_start), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data), 32'd0);
        check("t5_rst_send_done", 32'(send_done), 32'd0);
        check("t5_rst_send_err", 32'(send_err), 32'd0);
        rst = 1'b0;
        n = 0;
        while (tx_state && n < 100) begin tick(); n++; end
        repeat (5) tick();
        check("t5_no_restart", 32'(start_cnt), 32'd3);
        check("t5_idle", 32'(busy), 32'd0);
        write_frame1();
        repeat (T35 + 5) tick();
        clear_obs();
        request(9'd6);
        wait_done("t5_done");
        check_frame("t5", 8, frame1);

        // Write and request while busy are ignored.
        clear_obs();
        request(9'd6);
        tick();
        send_req = 1'b1; send_len = 9'd0;
        buf_wr_en = 1'b1; buf_wr_addr = 8'h00; buf_wr_data = 8'hFF;
        tick();
        send_req = 1'b0; buf_wr_en = 1'b0;
        check("t6_busy", 32'(busy), 32'd1);
        wait_done("t6_done");
        check_frame("t6", 8, frame1);
        repeat (2 * T35) tick();
        check("t6_no_second", 32'(start_cnt), 32'd8);
        check("t6_one_done", 32'(done_cnt), 32'd1);
        check("t6_no_err", 32'(err_cnt), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
